// File: rtl/uart_32bit_rx.sv
// uart_32bit_rx: 8N1 UART receiver that packs four consecutive bytes, LSB first,
// into a 32-bit word and presents it with a one-cycle valid strobe.
module uart_32bit_rx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        frame_err
);

   localparam int unsigned CntW          = $clog2(CLKS_PER_BIT);
   localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned ToW           = $clog2(TimeoutCycles);

   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [ToW-1:0]  ToLast   = ToW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic              rx_meta_q, rx_s_q;
   logic [CntW-1:0]   baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [23:0]       word_q, word_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [ToW-1:0]    tout_cnt_q, tout_cnt_d;
   logic [31:0]       data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              start_det;

   // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Bit-level FSM, word assembly and inter-byte timeout next-state logic.
   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      word_d       = word_q;
      byte_idx_d   = byte_idx_q;
      tout_cnt_d   = tout_cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      start_det    = 1'b0;

      unique case (state_q)
         StIdle: begin
            baud_cnt_d = '0;
            if (!rx_s_q) begin
               state_d   = StStart;
               start_det = 1'b1;
            end
         end
         StStart: begin
            if (baud_cnt_q == HalfLast) begin
               baud_cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = StData;
                  bit_idx_d = 3'd0;
               end else begin
                  // Line went back high before mid-start-bit: treat as a glitch.
                  state_d = StIdle;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (baud_cnt_q == FullLast) begin
               baud_cnt_d         = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (baud_cnt_q == FullLast) begin
               // Leave mid-stop-bit so a back-to-back start edge is not missed.
               baud_cnt_d = '0;
               state_d    = StIdle;
               if (rx_s_q) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  unique case (byte_idx_q)
                     2'd0: word_d[7:0]   = shift_q;
                     2'd1: word_d[15:8]  = shift_q;
                     2'd2: word_d[23:16] = shift_q;
                     2'd3: begin
                        data_out_d   = {shift_q, word_q};
                        data_valid_d = 1'b1;
                     end
                     default: ;
                  endcase
               end else begin
                  frame_err_d = 1'b1;
                  byte_idx_d  = 2'd0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Expiry drops the partial word even when a start edge arrives in the same cycle.
      if (state_q != StIdle || byte_idx_q == 2'd0) begin
         tout_cnt_d = '0;
      end else if (tout_cnt_q == ToLast) begin
         tout_cnt_d = '0;
         byte_idx_d = 2'd0;
      end else if (start_det) begin
         tout_cnt_d = '0;
      end else begin
         tout_cnt_d = tout_cnt_q + ToW'(1);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         baud_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         byte_idx_q   <= '0;
         tout_cnt_q   <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         byte_idx_q   <= byte_idx_d;
         tout_cnt_q   <= tout_cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;

endmodule
